// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - shares one SRAM-like port between instruction and data requesters
// Data requests win; a starvation counter forces an inst grant after STARVE_LIMIT data grants.
module sram_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [1:0]          mem_size,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic [3:0]          starve_q, starve_d;
  logic                wr_q, wr_d;
  logic [1:0]          size_q, size_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_buf_q, rdata_buf_d;
  logic [DATA_W-1:0]   inst_hold_q, inst_hold_d;
  logic [DATA_W-1:0]   data_hold_q, data_hold_d;
  logic                inst_grant, data_grant;

  assign inst_grant = inst_req && (!data_req || (starve_q == LIMIT));
  assign data_grant = data_req && !inst_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      starve_q    <= '0;
      wr_q        <= 1'b0;
      size_q      <= '0;
      wstrb_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_buf_q <= '0;
      inst_hold_q <= '0;
      data_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      wr_q        <= wr_d;
      size_q      <= size_d;
      wstrb_q     <= wstrb_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_buf_q <= rdata_buf_d;
      inst_hold_q <= inst_hold_d;
      data_hold_q <= data_hold_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    starve_d     = starve_q;
    wr_d         = wr_q;
    size_d       = size_q;
    wstrb_d      = wstrb_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_buf_d  = rdata_buf_q;
    inst_hold_d  = inst_hold_q;
    data_hold_d  = data_hold_q;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    mem_req      = 1'b0;

    // Handshakes are suppressed while rst is high so a dropped transaction never pulses.
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (inst_grant) begin
            inst_addr_ok = 1'b1;
            owner_d      = 1'b0;
            wr_d         = 1'b0;
            size_d       = 2'd2;
            wstrb_d      = '0;
            addr_d       = inst_addr;
            wdata_d      = '0;
            starve_d     = '0;
            state_d      = REQ;
          end else if (data_grant) begin
            data_addr_ok = 1'b1;
            owner_d      = 1'b1;
            wr_d         = data_wr;
            size_d       = data_size;
            wstrb_d      = data_wstrb;
            addr_d       = data_addr;
            wdata_d      = data_wdata;
            if (!inst_req)
              starve_d = '0;
            else if (starve_q != LIMIT)
              starve_d = starve_q + 4'd1;
            state_d      = REQ;
          end
        end
        REQ: begin
          mem_req = 1'b1;
          if (mem_addr_ok) begin
            if (mem_data_ok) begin
              rdata_buf_d = mem_rdata;
              state_d     = RESP;
            end else begin
              state_d     = WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_data_ok) begin
            rdata_buf_d = mem_rdata;
            state_d     = RESP;
          end
        end
        RESP: begin
          if (owner_q) begin
            data_data_ok = 1'b1;
            data_hold_d  = rdata_buf_q;
          end else begin
            inst_data_ok = 1'b1;
            inst_hold_d  = rdata_buf_q;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // The non-owner sees its previous response, not the current buffer.
  assign inst_rdata = (state_q == RESP && !owner_q) ? rdata_buf_q : inst_hold_q;
  assign data_rdata = (state_q == RESP &&  owner_q) ? rdata_buf_q : data_hold_q;

  assign mem_wr    = wr_q;
  assign mem_size  = size_q;
  assign mem_wstrb = wstrb_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
Shares one SRAM-like memory port between the IF-stage instruction requester and the MEM-stage data requester.
- Accepts one request at a time, holds it in a latch, issues it on the memory side, and routes the response back to the requester that owns it.
- Data requests have priority; a starvation counter guarantees instruction-fetch progress.
- Sits between the pipeline stages and the memory/bus bridge.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STARVE_LIMIT, 4, consecutive data grants allowed while inst_req is held before inst is forced (range 1..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
inst_req  in  1  instruction read request
inst_addr  in  ADDR_W  instruction address
inst_addr_ok  out  1  inst request accepted (1-cycle pulse)
inst_data_ok  out  1  inst read data valid (1-cycle pulse)
inst_rdata  out  DATA_W  instruction read data
data_req  in  1  data request
data_wr  in  1  1 = store, 0 = load
data_size  in  2  0 = byte, 1 = half, 2 = word
data_wstrb  in  DATA_W/8  store byte enables
data_addr  in  ADDR_W  data address
data_wdata  in  DATA_W  store data
data_addr_ok  out  1  data request accepted (1-cycle pulse)
data_data_ok  out  1  load data valid / store complete (1-cycle pulse)
data_rdata  out  DATA_W  load data
mem_req  out  1  memory-side request
mem_wr  out  1  memory-side write
mem_size  out  2  memory-side size
mem_wstrb  out  DATA_W/8  memory-side strobes
mem_addr  out  ADDR_W  memory-side address
mem_wdata  out  DATA_W  memory-side write data
mem_addr_ok  in  1  memory accepted mem_req
mem_data_ok  in  1  memory response valid
mem_rdata  in  DATA_W  memory read data

Behaviour:
FSM states: IDLE, REQ, WAIT, RESP. Reset: state = IDLE, owner = 0, starve_cnt = 0, all latches = 0, all outputs = 0.

IDLE:
- Combinational grant: data wins unless starve_cnt == STARVE_LIMIT and inst_req = 1.
- On grant, pulse the granted requester's addr_ok in the same cycle.
- Latch wr/size/wstrb/addr/wdata and owner (0 = inst, 1 = data), then go to REQ.
- Inst grant latches wr = 0, size = 2, wstrb = 0.
- No request: stay in IDLE.

starve_cnt (updated on each grant):
- Data grant while inst_req = 1: increment, saturating at STARVE_LIMIT.
- Inst grant: clear.
- Data grant with inst_req = 0: clear.

REQ:
- mem_req = 1; mem_* driven only from the latches, never from requester inputs.
- mem_addr_ok = 0: hold state and all values.
- mem_addr_ok = 1 with mem_data_ok = 0: go to WAIT.
- mem_addr_ok = 1 with mem_data_ok = 1 (same cycle): latch mem_rdata, go to RESP.

WAIT:
- mem_req = 0.
- mem_data_ok = 1: latch mem_rdata into rdata_buf, go to RESP.

RESP:
- Pulse owner's data_ok for exactly one cycle; inst_rdata/data_rdata = rdata_buf.
- The rdata of the requester that does not own the transaction is held at its last value.
- Go to IDLE. Next grant is earliest next cycle.
- Minimum request-to-data_ok latency: 3 cycles (accept, REQ with immediate addr_ok and data_ok, RESP).

Rules:
- Exactly one transaction outstanding; mem_data_ok in IDLE, REQ-without-addr_ok, or RESP is ignored.
- Requester inputs may change freely after addr_ok; the latched copy is used.
- Never both addr_ok in one cycle; never both data_ok in one cycle.
- Stores complete with data_data_ok; data_rdata is don't-care for stores but still loaded from mem_rdata.
- rst in any state returns to IDLE the next cycle: the in-flight transaction is dropped, no data_ok is pulsed, and starve_cnt is cleared.

Test Plan:
1. Single load: data_req = 1, addr 0x1C000010, memory addr_ok immediately and data_ok 2 cycles later with 0xDEADBEEF -> data_addr_ok pulse at cycle 0, mem_req high 1 cycle, data_data_ok pulse with data_rdata = 0xDEADBEEF, inst_* quiet.
2. Store byte: data_wr = 1, size 0, wstrb 0100, wdata 0x00AA0000 -> mem_wr = 1, mem_wstrb = 0100, mem_wdata = 0x00AA0000 held stable under 3 cycles of mem_addr_ok = 0; single data_data_ok.
3. Contention: inst_req and data_req held continuously, STARVE_LIMIT = 4 -> grant order D, D, D, D, I, D, D, D, D, I...; starve_cnt never exceeds 4.
4. Same-cycle mem_addr_ok and mem_data_ok on an inst fetch (rdata 0x02C00000) -> RESP next cycle, inst_data_ok with inst_rdata = 0x02C00000, total 3 cycles.
5. Spurious mem_data_ok in IDLE and in RESP -> no data_ok pulses, no state change.
6. rst asserted in WAIT -> next cycle all outputs 0, state IDLE; a later mem_data_ok produces no data_ok.
